i2c_slave_core: RTL and testbench
=================================

# i2c_slave_core

Synthesizable I2C slave with an internal byte register file; it is the downstream consumer of the bus-level I2C master model and responds to its write, combined write/read (repeated START) and NACK-terminated read sequences. SCL and SDA are oversampled on the system clock and the block never stretches SCL. Index auto-increments across multi-byte transfers. A side read port gives the bench and host logic direct visibility of register contents.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit device address matched against the first byte after START
- REG_NUM, 16, number of implemented 8-bit registers (1..256); index values ≥ REG_NUM are unimplemented
- CLK  input  1  system clock; must be ≥ 8× the SCL frequency
- RST  input  1  reset; one clock; reset is synchronous and active-high
- SCL  input  1  I2C clock (externally pulled up; slave only samples)
- SDA  inout  1  I2C data; open-drain: driven 1'b0 when sda_oe=1, else 1'bz
- busy  output  1  high from address match until STOP, repeated START to other address, or NACK
- wr_pulse  output  1  one-CLK strobe per register byte written
- wr_index  output  8  index of the byte written (valid with wr_pulse)
- wr_data  output  8  data written (valid with wr_pulse)
- dbg_idx  input  8  side read port index
- dbg_data  output  8  combinational register read of dbg_idx; 8'h00 if dbg_idx ≥ REG_NUM

## Operation
- Input conditioning: SCL and SDA each pass a 2-flop synchronizer plus one history flop; scl_rise, scl_fall, sda_rise, sda_fall are single-CLK pulses from stages 2/3.
- START (incl. repeated): sda_fall while synced SCL high → release SDA, bit_cnt=0, state ADDR, from any state.
- STOP: sda_rise while SCL high → release SDA, busy=0, state IDLE, from any state. START/STOP take priority over scl edges in the same CLK.
- Data sampled into shift register (MSB first) on scl_rise; SDA output updated only on scl_fall.
- States: IDLE, ADDR, ADDR_ACK, INDEX, INDEX_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE: ignore all SCL pulses (master issues trailing clocks after STOP/NACK).
- ADDR: after 8th scl_rise, compare [7:1] with SLAVE_ADDR. Match → ADDR_ACK, busy=1, on next scl_fall drive SDA low. Mismatch → IGNORE (SDA released, no ACK) until next START/STOP.
- ADDR_ACK: R/W=0 → release SDA on scl_fall ending ACK, go INDEX. R/W=1 → on that same scl_fall drive bit 7 of reg[index], go RDATA.
- INDEX: 8 bits → index register; ACK as above → WDATA.
- WDATA: 8 bits; on 8th scl_rise write reg[index] if index < REG_NUM (else discard), pulse wr_pulse/wr_index/wr_data regardless, index++ (8-bit wrap 8'hFF→8'h00). ACK always given → WDATA_ACK → WDATA.
- RDATA: shift out reg[index] (8'h00 if unimplemented), one bit per scl_fall; after 8th bit release SDA on scl_fall, index++, go RDATA_ACK.
- RDATA_ACK: sample SDA at scl_rise. 0 (ACK) → on scl_fall drive bit 7 of new reg[index], RDATA. 1 (NACK) → busy=0, IDLE, SDA stays released.
- Index persists across repeated START (write-index-then-read) and is not cleared by STOP.
- Reset: registers 8'h00, index 8'h00, state IDLE, sda_oe=0, busy=0, wr_pulse=0, wr_index=0, wr_data=0, synchronizers to 1.

## Timing
- Edge detect latency: 3 CLK from pin transition to edge pulse.
- SDA output change: ≤4 CLK after SCL falls at pin; must be stable ≥1 CLK before next SCL rise.
- wr_pulse asserted exactly 1 CLK, on the CLK after the 8th data scl_rise is detected.
- ACK held low from scl_fall after bit 8 through scl_fall after ACK clock.
- RST mid-transfer: SDA released next CLK; subsequent bus activity ignored until a new START.

## Test plan
- Write: START, 0xA0, index 0x02, data 0x11 0x22 0x33, STOP → three ACK bytes plus addr/index ACKs; reg[2..4]=11,22,33; three wr_pulse with wr_index 2,3,4.
- Read: write index 0x02, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP → bytes 11,22,33; busy falls at NACK; trailing 3 SCL pulses ignored.
- Address mismatch: START, 0xB0 → SDA high at ACK clock, no wr_pulse, busy=0, registers unchanged.
- Unimplemented/wrap: index 0xFF, write 0xAA,0xBB → wr_pulse idx FF then 00; reg[0]=0xBB, FF discarded; read at index 0x20 returns 0x00 with ACK.
- Abort: STOP after 4 data bits → no write, IDLE, SDA released; next write sequence works normally.
- Reset mid-read while slave drives 0 → SDA released in 1 CLK, all outputs reset values, reg contents cleared.

Source files
------------

// File: rtl/i2c_slave_core.sv
// I2C slave with an internal byte register file and auto-incrementing index.
// SCL/SDA are oversampled on CLK; SCL is never stretched.
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int          REG_NUM    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       busy,
    output logic       wr_pulse,
    output logic [7:0] wr_index,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_idx,
    output logic [7:0] dbg_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, INDEX, INDEX_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] scl_sync, sda_sync;
    logic [2:0] bit_cnt, cnt_nxt;
    logic [7:0] shreg, sh_nxt, sh_in;
    logic [7:0] index, index_nxt;
    logic [7:0] rd_byte;
    logic       sda_oe, oe_nxt, busy_nxt, wr_nxt;
    logic       scl_rise, scl_fall, sda_rise, sda_fall, sda_in, start, stop;
    logic [7:0] regs [REG_NUM];

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], SCL};
            sda_sync <= {sda_sync[1:0], SDA};
        end
    end

    assign scl_rise = scl_sync[1] & ~scl_sync[2];
    assign scl_fall = ~scl_sync[1] & scl_sync[2];
    assign sda_rise = sda_sync[1] & ~sda_sync[2];
    assign sda_fall = ~sda_sync[1] & sda_sync[2];
    assign sda_in   = sda_sync[1];
    assign start    = sda_fall & scl_sync[1];
    assign stop     = sda_rise & scl_sync[1];
    assign sh_in    = {shreg[6:0], sda_in};

    // Unimplemented indices read as zero on both the bus and the side port.
    always_comb begin
        rd_byte  = 8'h00;
        dbg_data = 8'h00;
        for (int i = 0; i < REG_NUM; i++) begin
            if (index == 8'(i))   rd_byte  = regs[i];
            if (dbg_idx == 8'(i)) dbg_data = regs[i];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sh_nxt    = shreg;
        index_nxt = index;
        oe_nxt    = sda_oe;
        busy_nxt  = busy;
        wr_nxt    = 1'b0;
        if (start) begin
            oe_nxt    = 1'b0;
            cnt_nxt   = 3'd0;
            state_nxt = ADDR;
        end else if (stop) begin
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    sh_nxt  = sh_in;
                    cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        busy_nxt  = (sh_in[7:1] == SLAVE_ADDR);
                        state_nxt = (sh_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                    end
                end
                INDEX, WDATA: if (scl_rise) begin
                    sh_nxt  = sh_in;
                    cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state == INDEX) begin
                            index_nxt = sh_in;
                            state_nxt = INDEX_ACK;
                        end else begin
                            wr_nxt    = 1'b1;
                            index_nxt = index + 8'd1;
                            state_nxt = WDATA_ACK;
                        end
                    end
                end
                // bit_cnt 0: fall ending bit 8 (drive ACK); 1: fall ending the ACK clock
                ADDR_ACK, INDEX_ACK, WDATA_ACK: if (scl_fall) begin
                    if (bit_cnt == 3'd0) begin
                        oe_nxt  = 1'b1;
                        cnt_nxt = 3'd1;
                    end else begin
                        cnt_nxt = 3'd0;
                        if (state == ADDR_ACK && shreg[0]) begin
                            oe_nxt    = ~rd_byte[7];
                            sh_nxt    = {rd_byte[6:0], 1'b0};
                            state_nxt = RDATA;
                        end else begin
                            oe_nxt    = 1'b0;
                            state_nxt = (state == ADDR_ACK) ? INDEX : WDATA;
                        end
                    end
                end
                RDATA: if (scl_fall) begin
                    if (bit_cnt == 3'd7) begin
                        oe_nxt    = 1'b0;
                        cnt_nxt   = 3'd0;
                        index_nxt = index + 8'd1;
                        state_nxt = RDATA_ACK;
                    end else begin
                        oe_nxt  = ~shreg[7];
                        sh_nxt  = {shreg[6:0], 1'b0};
                        cnt_nxt = bit_cnt + 3'd1;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && sda_in) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else if (scl_fall) begin
                        oe_nxt    = ~rd_byte[7];
                        sh_nxt    = {rd_byte[6:0], 1'b0};
                        state_nxt = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            index    <= 8'h00;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_index <= 8'h00;
            wr_data  <= 8'h00;
            for (int i = 0; i < REG_NUM; i++) regs[i] <= 8'h00;
        end else begin
            bit_cnt  <= cnt_nxt;
            shreg    <= sh_nxt;
            index    <= index_nxt;
            sda_oe   <= oe_nxt;
            busy     <= busy_nxt;
            wr_pulse <= wr_nxt;
            if (wr_nxt) begin
                wr_index <= index;
                wr_data  <= sh_in;
                for (int i = 0; i < REG_NUM; i++)
                    if (index == 8'(i)) regs[i] <= sh_in;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bus-level master tasks against a byte-array register model.
module tb_i2c_slave_core;

    localparam int Q       = 4;   // CLK cycles per quarter SCL period
    localparam int REG_NUM = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    logic [7:0] dbg_idx = 8'h00;
    wire        busy, wr_pulse;
    wire  [7:0] wr_index, wr_data, dbg_data;
    wire        sda;
    logic       sda_v;

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);
    assign sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;

    always #5 clk = ~clk;

    i2c_slave_core #(.SLAVE_ADDR(7'h50), .REG_NUM(REG_NUM)) dut (
        .CLK(clk), .RST(rst), .SCL(scl), .SDA(sda),
        .busy(busy), .wr_pulse(wr_pulse), .wr_index(wr_index), .wr_data(wr_data),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    int          n_chk = 0, n_fail = 0;
    logic [7:0]  mem [256];
    logic [7:0]  m_idx = 8'h00;
    logic [15:0] exp_q[$], got_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_rd(input logic [7:0] i);
        return (int'(i) < REG_NUM) ? mem[i] : 8'h00;
    endfunction

    always @(negedge clk) if (wr_pulse) got_q.push_back({wr_index, wr_data});

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock; entered and left with SCL low.
    task automatic bit_xfer(input logic b, output logic r);
        tick(Q); m_oe = ~b;
        tick(Q); scl = 1'b1;
        tick(Q); r = sda_v;
        tick(Q); scl = 1'b0;
    endtask

    task automatic bus_start;
        tick(Q); m_oe = 1'b0;
        tick(Q); scl = 1'b1;
        tick(Q); m_oe = 1'b1;
        tick(Q); scl = 1'b0;
    endtask

    task automatic bus_stop;
        tick(Q); m_oe = 1'b1;
        tick(Q); scl = 1'b1;
        tick(Q); m_oe = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic r;
        logic [7:0] t;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            t[i] = r;
        end
        bit_xfer(~ack, r);
        b = t;
    endtask

    task automatic chk_wr;
        chk("wr_cnt", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk("wr_evt", got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_regs;
        for (int i = 0; i < 33; i++) begin
            dbg_idx = (i == 32) ? 8'hFF : 8'(i);
            tick(1);
            chk("dbg_data", dbg_data, m_rd(dbg_idx));
        end
    endtask

    task automatic do_write(input logic [7:0] idx, input int n, input logic [31:0] data);
        logic a;
        logic [7:0] d;
        bus_start;
        send_byte(8'hA0, a); chk("w_addr_ack", a, 1);
        send_byte(idx, a);   chk("w_idx_ack", a, 1);
        m_idx = idx;
        for (int k = 0; k < n; k++) begin
            d = data[31-8*k -: 8];
            send_byte(d, a); chk("w_data_ack", a, 1);
            if (int'(m_idx) < REG_NUM) mem[m_idx] = d;
            exp_q.push_back({m_idx, d});
            m_idx = m_idx + 8'd1;
        end
        chk("busy_wr", busy, 1);
        bus_stop;
        chk("busy_stop", busy, 0);
        chk_wr;
    endtask

    task automatic do_read(input logic set_idx, input logic [7:0] idx, input int n, input logic trail);
        logic a, r;
        logic [7:0] d;
        bus_start;
        if (set_idx) begin
            send_byte(8'hA0, a); chk("r_addr0_ack", a, 1);
            send_byte(idx, a);   chk("r_idx_ack", a, 1);
            m_idx = idx;
            bus_start;
        end
        send_byte(8'hA1, a); chk("r_addr1_ack", a, 1);
        chk("busy_rd", busy, 1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k != n - 1, d);
            chk("rd_data", d, m_rd(m_idx));
            m_idx = m_idx + 8'd1;
        end
        chk("busy_nack", busy, 0);
        if (trail)
            for (int k = 0; k < 3; k++) begin
                bit_xfer(1'b1, r);
                chk("trail_sda", r, 1);
                chk("trail_busy", busy, 0);
            end
        bus_stop;
        chk_wr;
    endtask

    task automatic do_bad(input logic [6:0] adr);
        logic a;
        bus_start;
        send_byte({adr, 1'b0}, a); chk("bad_addr_ack", a, 0);
        chk("bad_busy", busy, 0);
        send_byte(8'h03, a);       chk("bad_data_ack", a, 0);
        bus_stop;
        chk_wr;
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog cycle budget expired");
        $fatal(1);
    end

    initial begin
        logic a, r;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        tick(3);
        chk("rst_sda", sda_v, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_wr_index", wr_index, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_dbg", dbg_data, 0);
        rst = 1'b0;
        tick(4);

        do_write(8'h02, 3, 32'h1122_3300);
        chk_regs;
        do_read(1'b1, 8'h02, 3, 1'b1);
        do_bad(7'h58);
        chk_regs;

        do_write(8'hFF, 2, 32'hAABB_0000);
        chk_regs;
        do_read(1'b1, 8'h20, 1, 1'b0);

        // STOP after four data bits: nothing written, index keeps the new value
        bus_start;
        send_byte(8'hA0, a); chk("ab_addr_ack", a, 1);
        send_byte(8'h05, a); chk("ab_idx_ack", a, 1);
        m_idx = 8'h05;
        for (int k = 0; k < 4; k++) bit_xfer(k[0], r);
        bus_stop;
        chk("ab_busy", busy, 0);
        chk("ab_sda", sda_v, 1);
        chk_wr;
        chk_regs;
        do_write(8'h06, 2, 32'h5A6B_0000);
        do_read(1'b0, 8'h00, 2, 1'b0);

        // Reset while the slave drives bit 7 (0) of reg[2] = 0x11
        bus_start;
        send_byte(8'hA0, a); chk("rr_addr_ack", a, 1);
        send_byte(8'h02, a); chk("rr_idx_ack", a, 1);
        bus_start;
        send_byte(8'hA1, a); chk("rr_addr1_ack", a, 1);
        tick(Q);
        chk("rr_drive_low", sda_v, 0);
        rst = 1'b1;
        tick(1);
        chk("rr_sda_rel", sda_v, 1);
        chk("rr_busy", busy, 0);
        chk("rr_wr_pulse", wr_pulse, 0);
        chk("rr_wr_index", wr_index, 0);
        chk("rr_wr_data", wr_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        m_idx = 8'h00;
        got_q.delete();
        chk_regs;
        scl = 1'b1;
        tick(2 * Q);
        chk("rr_idle_sda", sda_v, 1);

        for (int t = 0; t < 24; t++) begin
            int kind;
            logic [7:0] idx;
            kind = $urandom_range(0, 3);
            idx  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 19));
            case (kind)
                0: do_write(idx, $urandom_range(1, 4), $urandom);
                1: do_read(1'b1, idx, $urandom_range(1, 4), 1'b0);
                2: do_read(1'b0, 8'h00, $urandom_range(1, 3), 1'b0);
                default: begin
                    logic [6:0] adr;
                    adr = 7'($urandom_range(0, 127));
                    if (adr == 7'h50) adr = 7'h51;
                    do_bad(adr);
                end
            endcase
            dbg_idx = 8'($urandom_range(0, 31));
            tick(1);
            chk("rnd_dbg", dbg_data, m_rd(dbg_idx));
        end
        chk_regs;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
